mac_serial_core: RTL and testbench
==================================

Name: mac_serial_core

Overview:
Parametrised successor to the single-channel key loader/serial-output core. After a start pulse, it accepts NUM_KEYS data/coefficient word pairs over a valid/ready handshake. Each accepted pair is multiplied and accumulated into one of LANES accumulators, interleaved by word index, in unsigned or signed mode. When loading completes, all lane results are serialised MSB-first on P_out and the block pulses finish. It sits directly behind the input-file/host loader, in the position the original top core occupied.

Parameters:
DATA_W, 7, width of X_load data word
COEF_W, 8, width of W_load coefficient word
NUM_KEYS, 64, word pairs per job; must be a multiple of LANES, ≥ LANES
LANES, 4, number of interleaved accumulators/output channels
ACC_W, DATA_W+COEF_W+clog2(NUM_KEYS/LANES), accumulator width; derived, not overridden

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
start_in  in  1  start job; sampled in IDLE only
signed_en  in  1  1 = two's-complement operands; latched at start
valid_input  in  1  X_load/W_load valid this cycle
in_ready  out  1  block accepts a pair this cycle
X_load  in  DATA_W  data word
W_load  in  COEF_W  coefficient word
P_out  out  1  serial result bit
p_valid  out  1  P_out carries a result bit
finish  out  1  one-cycle job-done pulse
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (rst=1 at a clock edge, including mid-job): state=IDLE. in_ready, P_out, p_valid, finish and busy are all 0. Accumulators, word counter and bit counter are cleared, and signed flag=0.
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE: start_in=1 → LOAD next cycle. On the same edge: latch signed_en, clear all accumulators, set word counter=0. valid_input is ignored in IDLE.
- LOAD: in_ready=1. A pair is accepted on an edge where valid_input&&in_ready.
  - On accept: acc[idx mod LANES] += X*W (single-cycle MAC), then idx++.
  - Operands are zero-extended when unsigned, sign-extended when signed, to ACC_W before multiply.
  - Product is ACC_W bits. Overflow is impossible by the ACC_W rule; no saturation.
  - Cycles with valid_input=0 are stalls; state is held.
  - start_in is ignored during LOAD.
  - Accept of pair NUM_KEYS-1 → SHIFT next cycle; in_ready drops to 0 in that same next cycle.
- SHIFT: p_valid=1 for exactly LANES*ACC_W consecutive cycles.
  - Order: acc[0] MSB first through its LSB, then acc[1], …, then acc[LANES-1].
  - The first result bit appears in the first SHIFT cycle.
  - No backpressure. valid_input and start_in are ignored.
- DONE: finish=1 for one cycle, p_valid=0, then IDLE. A start_in present in that following IDLE cycle starts a new job; there is no extra bubble.
- Latency from last accept to first P_out bit: 1 cycle. From last accept to finish: LANES*ACC_W+1 cycles.
- P_out is 0 whenever p_valid=0. All outputs are registered.
- Defaults: ACC_W=19; serial phase is 76 cycles.

Decomposition:
- Shared package mac_serial_pkg holds:
  - state enum: IDLE, LOAD, SHIFT, DONE
  - clog2 function
  - ACC_W derivation function
  - lane-index width constant
- One sub-module, acc_piso: LANES×ACC_W accumulator bank with MAC-by-index and an MSB-first parallel-in/serial-out shift chain. The top contains the FSM, counters and handshake.

Test Plan:
- Reset: rst held 3 cycles, then released with no start → all outputs 0 and busy=0 for 20 cycles. Pulse rst mid-LOAD after 10 accepts → IDLE next cycle, in_ready=0. A new job then gives results with no residue from the aborted one.
- Unsigned, defaults, X=1, W=1 for all 64 pairs, continuous valid → 76 p_valid cycles, each lane = 19'd16 (bits 0…010000). finish arrives 77 cycles after the last accept.
- Signed: X=7'h7F (−1), W=8'h02 for all pairs → each lane = −32 = 19'h7FFE0. Same inputs with signed_en=0 → each lane = 16·127·2 = 19'd4064.
- Lane interleave: X=idx+1, W=1 unsigned → lane0=1+5+…+61=496, lane1=512, lane2=528, lane3=544, emitted in lane order.
- Stalls/ignored inputs:
  - valid_input toggles 1/0 randomly during LOAD → same results as continuous valid.
  - valid_input in IDLE/SHIFT and start_in during LOAD/SHIFT → no effect.
- Back-to-back jobs: start_in asserted in the cycle right after finish → second job starts. Max operands unsigned (X=127, W=255, all pairs) → each lane = 16·32385 = 19'd518160, no overflow.

Source files
------------

// File: rtl/mac_serial_pkg.sv
// Shared types and elaboration-time helpers for the serial MAC core.
//   state_t     : job phase (IDLE, LOAD, SHIFT, DONE)
//   clog2       : ceil(log2(n)), 0 for n <= 1
//   idx_width   : counter/index width, never less than 1 bit
//   acc_width   : accumulator width that makes a full job overflow-free
//   LANE_IDX_W  : lane-index width for the default lane count
package mac_serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int unsigned DEFAULT_DATA_W   = 7;
    localparam int unsigned DEFAULT_COEF_W   = 8;
    localparam int unsigned DEFAULT_NUM_KEYS = 64;
    localparam int unsigned DEFAULT_LANES    = 4;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int unsigned idx_width(input int unsigned n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    // Each lane sums NUM_KEYS/LANES full-width products.
    function automatic int unsigned acc_width(input int unsigned dw,
                                              input int unsigned cw,
                                              input int unsigned nk,
                                              input int unsigned lanes);
        return dw + cw + clog2(nk / lanes);
    endfunction

    localparam int unsigned LANE_IDX_W = idx_width(DEFAULT_LANES);

endpackage

// File: rtl/mac_serial_core_if.sv
// Load-side bus between the host/file loader and the MAC core.
//   valid_input : loader presents a data/coefficient pair
//   in_ready    : core accepts a pair this cycle
//   X_load      : data word
//   W_load      : coefficient word
// master = loader side, slave = core side.
interface mac_serial_core_if #(
    parameter int unsigned DATA_W = mac_serial_pkg::DEFAULT_DATA_W,
    parameter int unsigned COEF_W = mac_serial_pkg::DEFAULT_COEF_W
) ();

    logic              valid_input;
    logic              in_ready;
    logic [DATA_W-1:0] X_load;
    logic [COEF_W-1:0] W_load;

    modport master (
        output valid_input,
        output X_load,
        output W_load,
        input  in_ready
    );

    modport slave (
        input  valid_input,
        input  X_load,
        input  W_load,
        output in_ready
    );

endinterface

// File: rtl/mac_serial_core_acc_piso.sv
// Accumulator bank with interleaved MAC and an MSB-first serial shift chain.
//   clk, rst     : clock, synchronous active-high reset
//   clear        : zero every lane (job start)
//   mac_en       : add x*w into the lane selected by lane
//   lane         : target lane for the MAC
//   x, w         : operands, widened per signed_mode before multiplying
//   signed_mode  : 1 = two's-complement operands
//   shift_en     : shift the whole bank left one bit, lane 0 on top
//   head_next_c  : bit that will sit at the top of lane 0 after this edge
module acc_piso
    import mac_serial_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned COEF_W = DEFAULT_COEF_W,
    parameter int unsigned LANES  = DEFAULT_LANES,
    parameter int unsigned ACC_W  = acc_width(DEFAULT_DATA_W, DEFAULT_COEF_W,
                                              DEFAULT_NUM_KEYS, DEFAULT_LANES),
    parameter int unsigned LANE_W = LANE_IDX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              mac_en,
    input  logic [LANE_W-1:0] lane,
    input  logic [DATA_W-1:0] x,
    input  logic [COEF_W-1:0] w,
    input  logic              signed_mode,
    input  logic              shift_en,
    output logic              head_next_c
);

    logic [ACC_W-1:0] acc   [LANES];
    logic [ACC_W-1:0] acc_d [LANES];
    logic [ACC_W-1:0] x_ext;
    logic [ACC_W-1:0] w_ext;
    logic [ACC_W-1:0] prod;

    // Operand widening; the low ACC_W bits of the product are exact in both modes.
    always_comb begin
        if (signed_mode) begin
            x_ext = {{(ACC_W-DATA_W){x[DATA_W-1]}}, x};
            w_ext = {{(ACC_W-COEF_W){w[COEF_W-1]}}, w};
        end else begin
            x_ext = {{(ACC_W-DATA_W){1'b0}}, x};
            w_ext = {{(ACC_W-COEF_W){1'b0}}, w};
        end
        prod = x_ext * w_ext;
    end

    // Next bank value: clear, MAC into one lane, or shift the chain.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            acc_d[i] = acc[i];
        end
        if (clear) begin
            for (int i = 0; i < LANES; i++) begin
                acc_d[i] = '0;
            end
        end else if (mac_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (lane == LANE_W'(i)) begin
                    acc_d[i] = acc[i] + prod;
                end
            end
        end else if (shift_en) begin
            // Lane i pulls in the MSB of lane i+1, so lanes leave in index order.
            for (int i = 0; i < LANES - 1; i++) begin
                acc_d[i] = {acc[i][ACC_W-2:0], acc[i+1][ACC_W-1]};
            end
            acc_d[LANES-1] = {acc[LANES-1][ACC_W-2:0], 1'b0};
        end
    end

    assign head_next_c = acc_d[0][ACC_W-1];

    // Bank register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LANES; i++) begin
                acc[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LANES; i++) begin
                acc[i] <= acc_d[i];
            end
        end
    end

endmodule

// File: rtl/mac_serial_core.sv
// Job controller: loads NUM_KEYS pairs, MACs them into LANES interleaved
// accumulators, then streams every lane MSB-first and pulses finish.
//   clk, rst   : clock, synchronous active-high reset
//   start_in   : start a job (only looked at in IDLE)
//   signed_en  : operand mode, captured with start_in
//   bus        : load handshake (valid_input/in_ready, X_load, W_load)
//   P_out      : serial result bit, 0 when p_valid is low
//   p_valid    : P_out carries a result bit
//   finish     : one-cycle end-of-job pulse
//   busy       : high outside IDLE
module mac_serial_core
    import mac_serial_pkg::*;
#(
    parameter int unsigned DATA_W   = DEFAULT_DATA_W,
    parameter int unsigned COEF_W   = DEFAULT_COEF_W,
    parameter int unsigned NUM_KEYS = DEFAULT_NUM_KEYS,
    parameter int unsigned LANES    = DEFAULT_LANES
) (
    input  logic clk,
    input  logic rst,
    input  logic start_in,
    input  logic signed_en,
    mac_serial_core_if.slave bus,
    output logic P_out,
    output logic p_valid,
    output logic finish,
    output logic busy
);

    localparam int unsigned ACC_W  = acc_width(DATA_W, COEF_W, NUM_KEYS, LANES);
    localparam int unsigned IDX_W  = idx_width(NUM_KEYS);
    localparam int unsigned LANE_W = idx_width(LANES);
    localparam int unsigned SER_N  = LANES * ACC_W;
    localparam int unsigned BIT_W  = idx_width(SER_N);

    state_t            state;
    state_t            state_d;
    logic [IDX_W-1:0]  word_cnt;
    logic [LANE_W-1:0] lane_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic              signed_q;

    logic start_c;
    logic accept_c;
    logic shift_c;
    logic last_word_c;
    logic last_bit_c;
    logic head_next_c;

    assign start_c     = (state == IDLE) && start_in;
    assign accept_c    = (state == LOAD) && bus.valid_input && bus.in_ready;
    assign shift_c     = (state == SHIFT);
    assign last_word_c = (word_cnt == IDX_W'(NUM_KEYS - 1));
    assign last_bit_c  = (bit_cnt == BIT_W'(SER_N - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (start_in) state_d = LOAD;
            LOAD:    if (accept_c && last_word_c) state_d = SHIFT;
            SHIFT:   if (last_bit_c) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Word/lane/bit counters and the latched operand mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt <= '0;
            lane_cnt <= '0;
            bit_cnt  <= '0;
            signed_q <= 1'b0;
        end else if (start_c) begin
            word_cnt <= '0;
            lane_cnt <= '0;
            bit_cnt  <= '0;
            signed_q <= signed_en;
        end else if (accept_c) begin
            word_cnt <= word_cnt + 1'b1;
            lane_cnt <= (lane_cnt == LANE_W'(LANES - 1)) ? '0 : lane_cnt + 1'b1;
        end else if (shift_c) begin
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // Outputs follow the next state so each is valid in the cycle its state is entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.in_ready <= 1'b0;
            p_valid      <= 1'b0;
            P_out        <= 1'b0;
            finish       <= 1'b0;
            busy         <= 1'b0;
        end else begin
            bus.in_ready <= (state_d == LOAD);
            p_valid      <= (state_d == SHIFT);
            P_out        <= (state_d == SHIFT) && head_next_c;
            finish       <= (state_d == DONE);
            busy         <= (state_d != IDLE);
        end
    end

    acc_piso #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .LANES  (LANES),
        .ACC_W  (ACC_W),
        .LANE_W (LANE_W)
    ) u_acc_piso (
        .clk         (clk),
        .rst         (rst),
        .clear       (start_c),
        .mac_en      (accept_c),
        .lane        (lane_cnt),
        .x           (bus.X_load),
        .w           (bus.W_load),
        .signed_mode (signed_q),
        .shift_en    (shift_c),
        .head_next_c (head_next_c)
    );

endmodule

// File: tb/tb_mac_serial_core.sv
// Self-checking bench for mac_serial_core: directed and randomized jobs
// checked bit-by-bit against a lane-sum reference model.
module tb_mac_serial_core;

    localparam int unsigned DW  = 7;
    localparam int unsigned CW  = 8;
    localparam int unsigned NK  = 64;
    localparam int unsigned LN  = 4;
    localparam int unsigned AW  = 19;
    localparam int unsigned SER = LN * AW;

    logic clk = 1'b0;
    logic rst;
    logic start_in;
    logic signed_en;
    logic P_out;
    logic p_valid;
    logic finish;
    logic busy;

    mac_serial_core_if #(.DATA_W(DW), .COEF_W(CW)) bus ();

    mac_serial_core #(
        .DATA_W   (DW),
        .COEF_W   (CW),
        .NUM_KEYS (NK),
        .LANES    (LN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start_in  (start_in),
        .signed_en (signed_en),
        .bus       (bus.slave),
        .P_out     (P_out),
        .p_valid   (p_valid),
        .finish    (finish),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    bit          exp_bits[$];
    bit          got_bits[$];
    int unsigned xs [NK];
    int unsigned ws [NK];
    logic [AW-1:0] exp_lane [LN];
    logic [AW-1:0] got_lane [LN];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Serial stream checker: every p_valid bit is matched against the model queue.
    always @(negedge clk) begin : cmp
        bit b;
        if (p_valid === 1'b1) begin
            got_bits.push_back(P_out);
            if (exp_bits.size() == 0) begin
                check("extra_bit", {31'd0, p_valid}, 32'd0);
            end else begin
                b = exp_bits.pop_front();
                check("p_out_bit", {31'd0, P_out}, {31'd0, b});
            end
        end else begin
            check("p_out_idle", {31'd0, P_out}, 32'd0);
        end
    end

    // Reference: per-lane sums of the job's products, truncated to AW bits, MSB-first.
    task automatic build_expect(input bit sgn);
        longint sum [LN];
        longint xv;
        longint wv;
        logic [AW-1:0] v;
        for (int l = 0; l < LN; l++) sum[l] = 0;
        for (int k = 0; k < NK; k++) begin
            xv = longint'(xs[k]);
            wv = longint'(ws[k]);
            if (sgn && xs[k] >= 64)  xv = xv - 128;
            if (sgn && ws[k] >= 128) wv = wv - 256;
            sum[k % LN] += xv * wv;
        end
        exp_bits.delete();
        for (int l = 0; l < LN; l++) begin
            v = AW'(sum[l]);
            exp_lane[l] = v;
            for (int b = AW - 1; b >= 0; b--) exp_bits.push_back(v[b]);
        end
    endtask

    // Runs one job; entered and left #1 into a cycle in which the DUT is IDLE.
    task automatic run_job(input bit sgn, input int stall_pct, input bit junk);
        int st;
        logic [AW-1:0] v;
        build_expect(sgn);
        got_bits.delete();
        start_in  = 1'b1;
        signed_en = sgn;
        @(posedge clk); #1;
        start_in = 1'b0;
        if (junk) signed_en = 1'($urandom);
        for (int k = 0; k < NK; k++) begin
            st = (stall_pct > 0 && $urandom_range(99, 0) < stall_pct) ? $urandom_range(3, 1) : 0;
            repeat (st) begin
                bus.valid_input = 1'b0;
                bus.X_load = DW'($urandom);
                bus.W_load = CW'($urandom);
                if (junk) start_in = 1'($urandom);
                @(negedge clk);
                check("in_ready_stall", {31'd0, bus.in_ready}, 32'd1);
                @(posedge clk); #1;
            end
            start_in = junk ? 1'($urandom) : 1'b0;
            bus.valid_input = 1'b1;
            bus.X_load = DW'(xs[k]);
            bus.W_load = CW'(ws[k]);
            @(negedge clk);
            check("in_ready_load", {31'd0, bus.in_ready}, 32'd1);
            check("busy_load", {31'd0, busy}, 32'd1);
            @(posedge clk); #1;
        end
        bus.valid_input = 1'b0;
        start_in = 1'b0;
        for (int c = 1; c <= SER; c++) begin
            if (junk && c < SER) begin
                bus.valid_input = 1'($urandom);
                bus.X_load = DW'($urandom);
                bus.W_load = CW'($urandom);
                start_in = 1'($urandom);
            end else begin
                bus.valid_input = 1'b0;
                start_in = 1'b0;
            end
            @(negedge clk);
            check("p_valid_shift", {31'd0, p_valid}, 32'd1);
            check("finish_early", {31'd0, finish}, 32'd0);
            check("in_ready_shift", {31'd0, bus.in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        bus.valid_input = 1'b0;
        start_in = 1'b0;
        @(negedge clk);
        check("finish_pulse", {31'd0, finish}, 32'd1);
        check("p_valid_done", {31'd0, p_valid}, 32'd0);
        check("busy_done", {31'd0, busy}, 32'd1);
        check("bits_left", 32'(exp_bits.size()), 32'd0);
        check("bits_seen", 32'(got_bits.size()), 32'(SER));
        for (int l = 0; l < LN; l++) begin
            v = '0;
            for (int b = 0; b < AW; b++) begin
                v = {v[AW-2:0], (l * AW + b < got_bits.size()) ? got_bits[l * AW + b] : 1'b0};
            end
            got_lane[l] = v;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle_check(input int n, input bit junk);
        for (int i = 0; i < n; i++) begin
            start_in = 1'b0;
            bus.valid_input = junk ? 1'($urandom) : 1'b0;
            bus.X_load = DW'($urandom);
            bus.W_load = CW'($urandom);
            @(negedge clk);
            check("busy_idle", {31'd0, busy}, 32'd0);
            check("in_ready_idle", {31'd0, bus.in_ready}, 32'd0);
            check("p_valid_idle", {31'd0, p_valid}, 32'd0);
            check("finish_idle", {31'd0, finish}, 32'd0);
            @(posedge clk); #1;
        end
        bus.valid_input = 1'b0;
    endtask

    task automatic check_lanes(input string name, input logic [AW-1:0] l0, input logic [AW-1:0] l1,
                               input logic [AW-1:0] l2, input logic [AW-1:0] l3);
        logic [AW-1:0] want [LN];
        want[0] = l0; want[1] = l1; want[2] = l2; want[3] = l3;
        for (int l = 0; l < LN; l++) begin
            check($sformatf("%s_dut_lane%0d", name, l), {13'd0, got_lane[l]}, {13'd0, want[l]});
            check($sformatf("%s_model_lane%0d", name, l), {13'd0, exp_lane[l]}, {13'd0, want[l]});
        end
    endtask

    task automatic fill_const(input int unsigned x, input int unsigned w);
        for (int k = 0; k < NK; k++) begin
            xs[k] = x;
            ws[k] = w;
        end
    endtask

    task automatic fill_ramp();
        for (int k = 0; k < NK; k++) begin
            xs[k] = k + 1;
            ws[k] = 1;
        end
    endtask

    task automatic fill_rand();
        for (int k = 0; k < NK; k++) begin
            xs[k] = $urandom_range(127, 0);
            ws[k] = $urandom_range(255, 0);
        end
    endtask

    initial begin
        rst = 1'b1;
        start_in = 1'b0;
        signed_en = 1'b0;
        bus.valid_input = 1'b0;
        bus.X_load = '0;
        bus.W_load = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle_check(20, 1'b0);

        fill_const(1, 1);
        run_job(1'b0, 0, 1'b0);
        check_lanes("ones", 19'd16, 19'd16, 19'd16, 19'd16);
        idle_check(2, 1'b0);

        fill_const(7'h7F, 8'h02);
        run_job(1'b1, 0, 1'b0);
        check_lanes("neg1x2_signed", 19'h7FFE0, 19'h7FFE0, 19'h7FFE0, 19'h7FFE0);
        idle_check(2, 1'b0);
        run_job(1'b0, 0, 1'b0);
        check_lanes("neg1x2_unsigned", 19'd4064, 19'd4064, 19'd4064, 19'd4064);
        idle_check(2, 1'b0);

        fill_ramp();
        run_job(1'b0, 0, 1'b0);
        check_lanes("ramp", 19'd496, 19'd512, 19'd528, 19'd544);
        idle_check(5, 1'b1);
        run_job(1'b0, 40, 1'b1);
        check_lanes("ramp_stall", 19'd496, 19'd512, 19'd528, 19'd544);
        idle_check(2, 1'b0);

        // Abort after 10 accepts, then a clean job must show no residue.
        fill_rand();
        start_in = 1'b1;
        @(posedge clk); #1;
        start_in = 1'b0;
        for (int k = 0; k < 10; k++) begin
            bus.valid_input = 1'b1;
            bus.X_load = DW'(xs[k]);
            bus.W_load = CW'(ws[k]);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.valid_input = 1'b0;
        @(negedge clk);
        check("in_ready_after_abort", {31'd0, bus.in_ready}, 32'd0);
        check("busy_after_abort", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        fill_ramp();
        run_job(1'b0, 0, 1'b0);
        check_lanes("after_abort", 19'd496, 19'd512, 19'd528, 19'd544);

        // Back-to-back: next start sits in the IDLE cycle right after finish.
        fill_const(127, 255);
        run_job(1'b0, 0, 1'b0);
        check_lanes("max_unsigned", 19'd518160, 19'd518160, 19'd518160, 19'd518160);
        for (int j = 0; j < 4; j++) begin
            fill_rand();
            run_job(1'($urandom), 30, 1'b1);
            if (j == 1) idle_check(3, 1'b1);
        end
        idle_check(5, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
